// File: rtl/dma_xfer_ctrl.sv
// Single-channel memory-to-memory copy engine: alternates one read and one write
// per word from src to dst, with abort and a one-cycle done pulse.
module dma_xfer_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              nMR,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] addr,
    output logic              rd,
    output logic              wr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] remaining
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0]  dst_ptr_q, dst_ptr_d;
    logic [ADDR_W-1:0]  remaining_q, remaining_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    always_ff @(posedge clk or negedge nMR) begin
        if (!nMR) begin
            state_q     <= StIdle;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            wdata_q     <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        wdata_d     = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_ptr_d   = src;
                    dst_ptr_d   = dst;
                    remaining_d = len;
                    state_d     = (len == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                // abort wins over a coincident ack, leaving all fields frozen
                if (abort) begin
                    state_d = StIdle;
                end else if (mem_ack) begin
                    wdata_d = rdata;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (mem_ack) begin
                    src_ptr_d   = src_ptr_q + ADDR_W'(1);
                    dst_ptr_d   = dst_ptr_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                    state_d     = (remaining_q == ADDR_W'(1)) ? StDone : StRead;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        rd   = (state_q == StRead);
        wr   = (state_q == StWrite);
        busy = rd | wr;
        done = (state_q == StDone);
        addr = '0;
        if (rd) begin
            addr = src_ptr_q;
        end else if (wr) begin
            addr = dst_ptr_q;
        end
    end

    assign wdata     = wdata_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Directed bench for dma_xfer_ctrl: inputs driven and outputs checked on the falling edge.
module tb_dma_xfer_ctrl;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 8;

    logic              clk;
    logic              nMR;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] len;
    logic              mem_ack;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] remaining;

    int total = 0;
    int bad   = 0;

    dma_xfer_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk      (clk),
        .nMR      (nMR),
        .start    (start),
        .abort    (abort),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .mem_ack  (mem_ack),
        .rdata    (rdata),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .remaining(remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold READ for `waits` extra cycles, then ack with `data`; ends in the WRITE cycle.
    task automatic serve_read(input logic [ADDR_W-1:0] exp_addr, input logic [DATA_W-1:0] data,
                              input int waits);
        for (int i = 0; i < waits; i++) begin
            chk("rd_wait", {30'd0, rd, wr}, 32'h2);
            chk("rd_wait_addr", 32'(addr), 32'(exp_addr));
            @(negedge clk);
        end
        chk("rd", {30'd0, rd, wr}, 32'h2);
        chk("rd_addr", 32'(addr), 32'(exp_addr));
        chk("rd_busy", 32'(busy), 32'h1);
        mem_ack = 1'b1;
        rdata   = data;
        @(negedge clk);
        mem_ack = 1'b0;
        rdata   = '0;
        chk("wdata_cap", 32'(wdata), 32'(data));
    endtask

    task automatic serve_write(input logic [ADDR_W-1:0] exp_addr, input logic [DATA_W-1:0] data,
                               input logic [ADDR_W-1:0] exp_rem, input int waits);
        for (int i = 0; i < waits; i++) begin
            chk("wr_wait", {30'd0, rd, wr}, 32'h1);
            chk("wr_wait_addr", 32'(addr), 32'(exp_addr));
            @(negedge clk);
        end
        chk("wr", {30'd0, rd, wr}, 32'h1);
        chk("wr_addr", 32'(addr), 32'(exp_addr));
        chk("wr_data", 32'(wdata), 32'(data));
        chk("wr_rem", 32'(remaining), 32'(exp_rem));
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic kick(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                        input logic [ADDR_W-1:0] l);
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_done;
        chk("done_pulse", {29'd0, done, rd, wr}, 32'h4);
        chk("done_rem", 32'(remaining), 32'h0);
        @(negedge clk);
        chk("done_clear", {29'd0, done, busy, 1'b0}, 32'h0);
    endtask

    initial begin
        nMR = 1'b0; start = 1'b0; abort = 1'b0; mem_ack = 1'b0;
        src = '0; dst = '0; len = '0; rdata = '0;
        #1;
        chk("rst_outputs", {rd, wr, busy, done}, 32'h0);
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_rem", 32'(remaining), 32'h0);
        chk("rst_wdata", 32'(wdata), 32'h0);
        @(negedge clk);
        @(negedge clk);
        nMR = 1'b1;
        @(negedge clk);

        // Stray ack in IDLE has no effect
        mem_ack = 1'b1; rdata = 8'hEE;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_busy", 32'(busy), 32'h0);
        chk("idle_ack_wdata", 32'(wdata), 32'h0);

        // Basic copy
        kick(10'h010, 10'h200, 10'd3);
        chk("copy_rem0", 32'(remaining), 32'd3);
        serve_read(10'h010, 8'hA1, 1);
        serve_write(10'h200, 8'hA1, 10'd3, 1);
        serve_read(10'h011, 8'hB2, 1);
        serve_write(10'h201, 8'hB2, 10'd2, 1);
        serve_read(10'h012, 8'hC3, 1);
        serve_write(10'h202, 8'hC3, 10'd1, 1);
        expect_done();

        // Address wrap
        kick(10'h3FE, 10'h3FF, 10'd2);
        serve_read(10'h3FE, 8'h11, 0);
        serve_write(10'h3FF, 8'h11, 10'd2, 0);
        serve_read(10'h3FF, 8'h22, 0);
        serve_write(10'h000, 8'h22, 10'd1, 0);
        expect_done();

        // Zero length
        kick(10'h123, 10'h234, 10'd0);
        expect_done();
        chk("zero_idle", {30'd0, rd, wr}, 32'h0);

        // Abort coinciding with ack in the 2nd WRITE
        kick(10'h020, 10'h040, 10'd5);
        serve_read(10'h020, 8'h33, 0);
        serve_write(10'h040, 8'h33, 10'd5, 0);
        serve_read(10'h021, 8'h44, 0);
        chk("abort_wr_addr", 32'(addr), 32'h041);
        mem_ack = 1'b1; abort = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0; abort = 1'b0;
        chk("abort_idle", {29'd0, busy, done, rd}, 32'h0);
        chk("abort_rem", 32'(remaining), 32'd4);
        chk("abort_addr", 32'(addr), 32'h0);
        @(negedge clk);
        chk("abort_no_done", 32'(done), 32'h0);

        // Wait states with start re-pulsed mid-transfer
        kick(10'h100, 10'h180, 10'd2);
        src = 10'h3AA; dst = 10'h0AA; len = 10'd9; start = 1'b1;
        serve_read(10'h100, 8'h55, 4);
        serve_write(10'h180, 8'h55, 10'd2, 4);
        start = 1'b0;
        serve_read(10'h101, 8'h66, 4);
        serve_write(10'h181, 8'h66, 10'd1, 4);
        expect_done();

        // Asynchronous reset mid-WRITE
        kick(10'h050, 10'h060, 10'd3);
        serve_read(10'h050, 8'h77, 0);
        chk("pre_rst_wr", 32'(wr), 32'h1);
        #2 nMR = 1'b0;
        #1;
        chk("arst_strobes", {29'd0, rd, wr, busy}, 32'h0);
        chk("arst_addr", 32'(addr), 32'h0);
        chk("arst_wdata", 32'(wdata), 32'h0);
        chk("arst_rem", 32'(remaining), 32'h0);
        @(negedge clk);
        nMR = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, busy, done}, 32'h0);
        kick(10'h070, 10'h080, 10'd1);
        serve_read(10'h070, 8'h5A, 0);
        serve_write(10'h080, 8'h5A, 10'd1, 0);
        expect_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
